// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback path: default widths,
// source identifiers and the writeback result payload.
package wb_pkg;

  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_NUM_REGS   = 1 << WB_ADDR_WIDTH;
  localparam int STAT_WIDTH    = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_t;

  // Field is named rd because "reg" is a reserved word.
  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] rd;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_result_t;

endpackage

// File: rtl/wb_rr_arbiter2.sv
// Two-requester round-robin arbiter; last_grant moves on every transfer, and
// both grants are held low while reset is asserted.
module wb_rr_arbiter2
  import wb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_alu,
  input  logic req_mem,
  output logic grant_alu,
  output logic grant_mem
);

  src_t last_grant;
  src_t last_grant_next;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_alu       = 1'b0;
    grant_mem       = 1'b0;
    last_grant_next = last_grant;
    if (!reset) begin
      if (req_alu && req_mem) begin
        grant_alu = (last_grant == SRC_MEM);
        grant_mem = (last_grant == SRC_ALU);
      end else begin
        grant_alu = req_alu;
        grant_mem = req_mem;
      end
    end
    // A grant is only ever given to a valid requester, so a grant is a transfer.
    if (grant_alu) begin
      last_grant_next = SRC_ALU;
    end else if (grant_mem) begin
      last_grant_next = SRC_MEM;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= SRC_MEM;
    end else begin
      last_grant <= last_grant_next;
    end
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Writeback arbiter: merges ALU and load results into the register-file write
// port, which also serves as the forwarding source, and keeps a busy scoreboard.
// Defining WB_STATS_EN adds saturating transfer and conflict counters.
module regfile_writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  localparam int NUM_REGS  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_reg,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_reg,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_reg,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  rf_write_en,
  output logic [ADDR_WIDTH-1:0] rf_write_reg,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic [NUM_REGS-1:0]   busy
`ifdef WB_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] alu_wr_count,
  output logic [STAT_WIDTH-1:0] mem_wr_count,
  output logic [STAT_WIDTH-1:0] conflict_count
`endif
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } result_t;

  logic          grant_alu;
  logic          grant_mem;
  logic          transfer;
  result_t       winner;
  logic [NUM_REGS-1:0] busy_next;

  wb_rr_arbiter2 u_arbiter (
    .clk       (clk),
    .reset     (reset),
    .req_alu   (alu_valid),
    .req_mem   (mem_valid),
    .grant_alu (grant_alu),
    .grant_mem (grant_mem)
  );

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;
  assign transfer  = grant_alu || grant_mem;

  always_comb begin
    winner = '{rd: alu_reg, data: alu_data};
    if (grant_mem) begin
      winner = '{rd: mem_reg, data: mem_data};
    end
  end

  // R0 results are accepted but never reach the register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_write_en   <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
    end else if (transfer) begin
      rf_write_en   <= (winner.rd != '0);
      rf_write_reg  <= winner.rd;
      rf_write_data <= winner.data;
    end else begin
      rf_write_en   <= 1'b0;
    end
  end

  // Clear is applied before set so a same-edge issue to the committing register wins.
  always_comb begin
    busy_next = busy;
    if (rf_write_en) begin
      busy_next[rf_write_reg] = 1'b0;
    end
    if (issue_valid && (issue_reg != '0)) begin
      busy_next[issue_reg] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // NOTE: the scoreboard is a handful of flops, not a RAM, so it is safe to reset in full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

`ifdef WB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_wr_count   <= '0;
      mem_wr_count   <= '0;
      conflict_count <= '0;
    end else begin
      if (grant_alu && (alu_wr_count != '1)) begin
        alu_wr_count <= alu_wr_count + 1'b1;
      end
      if (grant_mem && (mem_wr_count != '1)) begin
        mem_wr_count <= mem_wr_count + 1'b1;
      end
      if (alu_valid && mem_valid && (conflict_count != '1)) begin
        conflict_count <= conflict_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Self-checking bench for regfile_writeback_arbiter: directed scenarios plus a
// randomized phase, all checked against a transaction-level reference model.
module tb_regfile_writeback_arbiter;
  import wb_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid;
  logic [AW-1:0] issue_reg;
  logic          alu_valid, mem_valid;
  logic          alu_ready, mem_ready;
  logic [AW-1:0] alu_reg, mem_reg;
  logic [DW-1:0] alu_data, mem_data;
  logic          rf_write_en;
  logic [AW-1:0] rf_write_reg;
  logic [DW-1:0] rf_write_data;
  logic [NR-1:0] busy;
`ifdef WB_STATS_EN
  logic [31:0] alu_wr_count, mem_wr_count, conflict_count;
`endif

  regfile_writeback_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_reg     (issue_reg),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_reg       (alu_reg),
    .alu_data      (alu_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_reg       (mem_reg),
    .mem_data      (mem_data),
    .rf_write_en   (rf_write_en),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .busy          (busy)
`ifdef WB_STATS_EN
    ,
    .alu_wr_count  (alu_wr_count),
    .mem_wr_count  (mem_wr_count),
    .conflict_count(conflict_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the pending write, the register set with pending writes,
  // whose turn it is on a conflict, and the transfer/conflict tallies.
  bit          m_wen;
  bit [AW-1:0] m_wreg;
  bit [DW-1:0] m_wdata;
  bit [NR-1:0] m_busy;
  bit          m_mem_went_last;
  int          m_alu_cnt, m_mem_cnt, m_conf_cnt;
  bit          acc_alu, acc_mem;
  bit [3:0]    grant_seq;
  bit [NR-1:0] busy_before;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_reg = '0;
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
  endtask

  task automatic model_reset();
    m_wen = 1'b0; m_wreg = '0; m_wdata = '0; m_busy = '0;
    m_mem_went_last = 1'b1;
    m_alu_cnt = 0; m_mem_cnt = 0; m_conf_cnt = 0;
    acc_alu = 1'b0; acc_mem = 1'b0;
  endtask

  // Asserts reset immediately (asynchronously), checks the cleared state,
  // then releases it away from a clock edge and realigns to posedge+1.
  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    alu_valid = 1'b1;
    mem_valid = 1'b1;
    model_reset();
    #1;
    check("rst_wen", 64'(rf_write_en), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_alu_ready", 64'(alu_ready), 64'(0));
    check("rst_mem_ready", 64'(mem_ready), 64'(0));
    @(posedge clk);
    idle_inputs();
    @(negedge clk);
    check("rst_wreg", 64'(rf_write_reg), 64'(0));
    check("rst_wdata", 64'(rf_write_data), 64'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One clock: check grants mid-cycle, advance the model across the edge,
  // then check the registered outputs just after the edge.
  task automatic step();
    bit ea, em;
    @(negedge clk);
    ea = alu_valid && (!mem_valid || m_mem_went_last);
    em = mem_valid && !ea;
    check("alu_ready", 64'(alu_ready), 64'(ea));
    check("mem_ready", 64'(mem_ready), 64'(em));
    if (m_wen) m_busy[m_wreg] = 1'b0;
    if (issue_valid && issue_reg != 0) m_busy[issue_reg] = 1'b1;
    if (alu_valid && mem_valid) m_conf_cnt++;
    if (ea) begin
      m_alu_cnt++;
      m_wen = (alu_reg != 0); m_wreg = alu_reg; m_wdata = alu_data;
      m_mem_went_last = 1'b0;
    end else if (em) begin
      m_mem_cnt++;
      m_wen = (mem_reg != 0); m_wreg = mem_reg; m_wdata = mem_data;
      m_mem_went_last = 1'b1;
    end else begin
      m_wen = 1'b0;
    end
    acc_alu = ea;
    acc_mem = em;
    @(posedge clk);
    #1;
    check("wen", 64'(rf_write_en), 64'(m_wen));
    check("wreg", 64'(rf_write_reg), 64'(m_wreg));
    check("wdata", 64'(rf_write_data), 64'(m_wdata));
    check("busy", 64'(busy), 64'(m_busy));
`ifdef WB_STATS_EN
    check("alu_cnt", 64'(alu_wr_count), 64'(m_alu_cnt));
    check("mem_cnt", 64'(mem_wr_count), 64'(m_mem_cnt));
    check("conf_cnt", 64'(conflict_count), 64'(m_conf_cnt));
`endif
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #2;
    do_reset();

    // Single ALU write: accepted at once, visible for exactly one cycle.
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'hDEADBEEF;
    step();
    check("t1_ready", 64'(acc_alu), 64'(1));
    check("t1_wen", 64'(rf_write_en), 64'(1));
    check("t1_wreg", 64'(rf_write_reg), 64'(3));
    check("t1_wdata", 64'(rf_write_data), 64'(32'hDEADBEEF));
    idle_inputs();
    step();
    check("t1_wen_drop", 64'(rf_write_en), 64'(0));

    // Sustained conflict after reset alternates starting with the ALU.
    do_reset();
    alu_valid = 1'b1; alu_reg = 5'd1; alu_data = 32'hA1A1A1A1;
    mem_valid = 1'b1; mem_reg = 5'd2; mem_data = 32'hB2B2B2B2;
    for (int i = 0; i < 4; i++) begin
      step();
      grant_seq[3-i] = acc_alu;
      check("conflict_one_ready", 64'(acc_alu ^ acc_mem), 64'(1));
    end
    check("conflict_order", 64'(grant_seq), 64'(4'b1010));
    idle_inputs();
    step();

    // Load to R0 is consumed without a write and without touching busy.
    busy_before = busy;
    mem_valid = 1'b1; mem_reg = 5'd0; mem_data = 32'h1234;
    step();
    check("r0_ready", 64'(acc_mem), 64'(1));
    check("r0_no_write", 64'(rf_write_en), 64'(0));
    check("r0_busy", 64'(busy), 64'(busy_before));
    idle_inputs();

    // Scoreboard set/clear, then a re-issue landing on the clear edge.
    for (int rep = 0; rep < 2; rep++) begin
      issue_valid = 1'b1; issue_reg = 5'd5;
      step();
      check("sb_set", 64'(busy[5]), 64'(1));
      idle_inputs();
      step();
      step();
      alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'h55550000 + 32'(rep);
      step();
      check("sb_inflight", 64'(busy[5]), 64'(1));
      idle_inputs();
      if (rep == 1) begin
        issue_valid = 1'b1; issue_reg = 5'd5;
      end
      step();
      check("sb_after_commit", 64'(busy[5]), 64'(rep));
      idle_inputs();
    end

    // Reset while a write to R7 is in the output stage drops it.
    issue_valid = 1'b1; issue_reg = 5'd7;
    step();
    idle_inputs();
    alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'h77777777;
    step();
    check("mid_wen_before", 64'(rf_write_en), 64'(1));
    do_reset();
    step();
    check("mid_no_write", 64'(rf_write_en), 64'(0));

    // Randomized traffic with legal handshakes (payload held until accepted).
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      if (!alu_valid || acc_alu) begin
        alu_valid = ($urandom_range(0, 3) != 0);
        alu_reg   = AW'($urandom);
        alu_data  = $urandom;
      end
      if (!mem_valid || acc_mem) begin
        mem_valid = ($urandom_range(0, 3) != 0);
        mem_reg   = AW'($urandom);
        mem_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 1) != 0);
      issue_reg   = AW'($urandom);
      step();
    end

`ifdef WB_STATS_EN
    // Two conflict cycles, then solo traffic: 5 ALU, 3 MEM, 2 conflicts.
    do_reset();
    alu_valid = 1'b1; alu_reg = 5'd4; alu_data = 32'h1;
    mem_valid = 1'b1; mem_reg = 5'd6; mem_data = 32'h2;
    step();
    alu_reg = 5'd8; alu_data = 32'h3;
    step();
    mem_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      alu_reg = AW'(10 + i); alu_data = 32'(i);
      step();
    end
    alu_valid = 1'b0; mem_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mem_reg = AW'(20 + i); mem_data = 32'(i);
      step();
    end
    idle_inputs();
    step();
    check("stats_alu", 64'(alu_wr_count), 64'(5));
    check("stats_mem", 64'(mem_wr_count), 64'(3));
    check("stats_conf", 64'(conflict_count), 64'(2));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_arbiter.md
Name: regfile_writeback_arbiter

Overview:
Write-side initiator for the CPU register file.
- Merges writeback results from the ALU and the load/memory unit through valid/ready handshakes.
- Registers the winning result and drives the register file's write_en/write_reg/write_data port.
- Keeps a per-register busy scoreboard for hazard logic.
- Its registered output stage doubles as the forwarding source for in-flight writes.

Parameters:
DATA_WIDTH, 32, width of write data
ADDR_WIDTH, 5, register address width; NUM_REGS = 1<<ADDR_WIDTH

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
issue_valid  input  1  an instruction with a destination register is issued this cycle
issue_reg  input  ADDR_WIDTH  destination register of the issued instruction
alu_valid  input  1  ALU result available
alu_ready  output  1  ALU result accepted this cycle
alu_reg  input  ADDR_WIDTH  ALU destination register
alu_data  input  DATA_WIDTH  ALU result
mem_valid  input  1  load result available
mem_ready  output  1  load result accepted this cycle
mem_reg  input  ADDR_WIDTH  load destination register
mem_data  input  DATA_WIDTH  load result
rf_write_en  output  1  register file write enable; also forwarding valid
rf_write_reg  output  ADDR_WIDTH  register file write address
rf_write_data  output  DATA_WIDTH  register file write data
busy  output  NUM_REGS  scoreboard; bit n set = write to Rn pending

Behaviour:
- Reset (async): rf_write_en=0, rf_write_reg=0, rf_write_data=0, busy=0, last_grant=MEM (so ALU wins the first conflict). alu_ready/mem_ready=0 while reset is asserted.
- Arbitration (combinational):
  - Only one source valid -> that source is granted.
  - Both valid -> grant the source not in last_grant.
  - alu_ready = grant_alu; mem_ready = grant_mem. At most one ready per cycle.
- Handshake: transfer occurs when valid&&ready. A source must hold valid and a stable payload until ready. last_grant updates on every transfer.
- Output stage, posedge with a transfer:
  - rf_write_reg/rf_write_data <= winner payload.
  - rf_write_en <= (winner reg != 0).
  - A write to R0 is consumed and dropped; no write is issued.
- Output stage, posedge without a transfer: rf_write_en <= 0; rf_write_reg/rf_write_data hold their values.
- Latency:
  - Accept at edge N -> rf_write_en high during cycle N..N+1.
  - Register file commits at edge N+1.
  - Readers must forward from rf_write_* while rf_write_en is high.
- Throughput: one write per cycle. A sustained conflict alternates ALU/MEM strictly.
- Scoreboard, per posedge:
  - Set busy[issue_reg] if issue_valid && issue_reg != 0.
  - Clear busy[rf_write_reg] if rf_write_en (same edge the register file commits).
  - Set and clear of the same register on the same edge -> set wins.
  - busy[0] is constant 0.
  - Issuing to an already-busy register leaves the bit set. Preventing WAW is the issue stage's responsibility.
- Reset mid-operation drops any in-flight output-stage write. The register file is reset concurrently by the same signal.

Optional Feature:
WB_STATS_EN
- Defined: adds outputs alu_wr_count, mem_wr_count and conflict_count (32 bits each), all saturating and reset to 0.
  - alu_wr_count / mem_wr_count increment per accepted transfer from that source, R0 drops included.
  - conflict_count increments per cycle with both sources valid.
- Undefined: the counters and their ports are absent. Core behaviour is identical.

Decomposition:
- Shared package wb_pkg: DATA_WIDTH/ADDR_WIDTH defaults, NUM_REGS, source IDs SRC_ALU=0 and SRC_MEM=1, and the result payload struct {reg, data}.
- One sub-module, wb_rr_arbiter2: 2-requester round-robin arbiter holding last_grant. Its state updates on transfer.

Test Plan:
- Reset, then alu_valid=1, reg=3, data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle rf_write_en=1, rf_write_reg=3, rf_write_data=0xDEADBEEF; then rf_write_en=0.
- Both valid for 4 cycles (ALU reg 1, MEM reg 2, held) after reset -> grants in order ALU, MEM, ALU, MEM; the ready of the losing source stays 0.
- mem_valid with reg=0, data=0x1234 -> mem_ready=1; rf_write_en stays 0 next cycle; busy unchanged.
- issue_valid reg=5 -> busy[5]=1; ALU write to R5 accepted 3 cycles later -> busy[5] clears at the edge where rf_write_en=1. Repeat with issue_valid reg=5 coinciding with that clear edge -> busy[5] stays 1.
- Assert reset while rf_write_en=1 for reg 7 -> rf_write_en=0 and busy=0 immediately; no write is issued after reset releases.
- With WB_STATS_EN: 5 ALU writes, 3 MEM writes, 2 conflict cycles -> alu_wr_count=5, mem_wr_count=3, conflict_count=2.
